// File: rtl/rcpfa_serial_ctrl.sv
// Purpose: bit-serial add/subtract controller driving one combinational rcpfa cell, LSB first.
// Latency: start sampled at edge E0 -> done high in the cycle after edge E0+WIDTH; one op per WIDTH+2 cycles.
// Backpressure: none; start is only sampled in IDLE and is dropped (not queued) while busy.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   start, sub, a, b, cin   request and operands (sampled together in IDLE)
//   busy, done              status; done is a one-cycle pulse
//   sum, cout, ovf          result, carry out of MSB, signed overflow (held until next done)
//   cell_ai/bi/ci1/fi       drive to the rcpfa cell (only non-zero in RUN; fi always 0)
//   cell_si/ci/fi1          returned sum bit / carry out / unused fi1 from the cell
module rcpfa_serial_ctrl #(
  parameter int WIDTH = 8,
  localparam int CW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             cell_ai,
  output logic             cell_bi,
  output logic             cell_ci1,
  output logic             cell_fi,
  input  logic             cell_si,
  input  logic             cell_ci,
  input  logic             cell_fi1
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic             carry_q, carry_d;
  logic             cmsb_q, cmsb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // Final bit of the cycle: the cell has just produced the MSB sum bit.
  logic last_bit;
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // s_sh_q[0] falls off the end on the last shift and cell_fi1 has no use here.
  logic unused_ok;
  assign unused_ok = ^{cell_fi1, s_sh_q[0]};

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    cell_ai  = 1'b0;
    cell_bi  = 1'b0;
    cell_ci1 = 1'b0;
    cell_fi  = 1'b0;
    case (state_q)
      S_RUN: begin
        busy     = 1'b1;
        cell_ai  = a_sh_q[0];
        cell_bi  = b_sh_q[0];
        cell_ci1 = carry_q;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

  // ---------------- datapath next values ----------------
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          // Subtract as a + ~b + 1: the +1 rides in through the initial carry.
          b_sh_d  = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        s_sh_d  = {cell_si, s_sh_q[WIDTH-1:1]};
        carry_d = cell_ci;
        cnt_d   = cnt_q + CW'(1);
        // Carry out of bit WIDTH-2 is the carry into the MSB, needed for overflow.
        if (cnt_q == CW'(WIDTH - 2)) cmsb_d = cell_ci;
        if (last_bit) begin
          sum_d  = {cell_si, s_sh_q[WIDTH-1:1]};
          cout_d = cell_ci;
          ovf_d  = cmsb_q ^ cell_ci;
        end
      end
      default: ;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_rcpfa_serial_ctrl.sv
// Purpose: directed and randomised self-checking bench for rcpfa_serial_ctrl with a behavioural cell.
// Latency: expects done exactly WIDTH clock edges after the edge that samples start.
// Backpressure: exercises start pulses while busy (RUN and DONE) and checks they are dropped.
module tb_rcpfa_serial_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             cell_ai, cell_bi, cell_ci1, cell_fi;
  logic             cell_si, cell_ci, cell_fi1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Behavioural rcpfa cell: full adder.
  assign cell_si  = cell_ai ^ cell_bi ^ cell_ci1;
  assign cell_ci  = (cell_ai & cell_bi) | (cell_ai & cell_ci1) | (cell_bi & cell_ci1);
  assign cell_fi1 = 1'b0;

  rcpfa_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .cell_ai  (cell_ai),
    .cell_bi  (cell_bi),
    .cell_ci1 (cell_ci1),
    .cell_fi  (cell_fi),
    .cell_si  (cell_si),
    .cell_ci  (cell_ci),
    .cell_fi1 (cell_fi1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise start for one cycle; returns 1ns after the sampling edge E0.
  // Operands are scrambled afterwards so any late resampling would show.
  task automatic do_start(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_op,
                          input logic tcin, input logic tsub);
    a = ta; b = tb_op; cin = tcin; sub = tsub; start = 1'b1;
    tick();
    start = 1'b0; a = ~ta; b = ~tb_op; cin = ~tcin; sub = ~tsub;
  endtask

  // Counts edges from E0 until done is seen (bounded).
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if ({sum, cout, ovf} !== 10'h0) begin n_err++; $display("FAIL reset_result got=%h/%b/%b exp=00/0/0", sum, cout, ovf); end
    n_cmp++; if ({cell_ai, cell_bi, cell_ci1, cell_fi} !== 4'b0) begin n_err++; $display("FAIL reset_cell got=%b exp=0000", {cell_ai, cell_bi, cell_ci1, cell_fi}); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_add();
    int cyc;
    do_start(8'h5A, 8'h33, 1'b0, 1'b0);
    wait_done(cyc);
    n_cmp++; if (cyc !== WIDTH) begin n_err++; $display("FAIL add_latency got=%0d exp=%0d", cyc, WIDTH); end
    n_cmp++; if (sum !== 8'h8D) begin n_err++; $display("FAIL add_sum got=%h exp=8d", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL add_cout got=%b exp=0", cout); end
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL add_ovf got=%b exp=1", ovf); end
    tick();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL add_after got=done%b busy%b exp=done0 busy0", done, busy); end
    n_cmp++; if (sum !== 8'h8D) begin n_err++; $display("FAIL add_hold got=%h exp=8d", sum); end
  endtask

  task automatic test_ripple();
    int cyc;
    do_start(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done(cyc);
    n_cmp++; if ({sum, cout, ovf} !== {8'h00, 1'b1, 1'b0}) begin n_err++; $display("FAIL ripple_b1 got=%h/%b/%b exp=00/1/0", sum, cout, ovf); end
    tick();
    do_start(8'hFF, 8'h00, 1'b1, 1'b0);
    wait_done(cyc);
    n_cmp++; if (cyc !== WIDTH) begin n_err++; $display("FAIL ripple_latency got=%0d exp=%0d", cyc, WIDTH); end
    n_cmp++; if ({sum, cout, ovf} !== {8'h00, 1'b1, 1'b0}) begin n_err++; $display("FAIL ripple_cin got=%h/%b/%b exp=00/1/0", sum, cout, ovf); end
    tick();
  endtask

  task automatic test_sub();
    int cyc;
    do_start(8'h10, 8'h20, 1'b1, 1'b1);
    wait_done(cyc);
    n_cmp++; if ({sum, cout, ovf} !== {8'hF0, 1'b0, 1'b0}) begin n_err++; $display("FAIL sub_borrow got=%h/%b/%b exp=f0/0/0", sum, cout, ovf); end
    tick();
    do_start(8'h80, 8'h01, 1'b0, 1'b1);
    wait_done(cyc);
    n_cmp++; if ({sum, cout, ovf} !== {8'h7F, 1'b1, 1'b1}) begin n_err++; $display("FAIL sub_ovf got=%h/%b/%b exp=7f/1/1", sum, cout, ovf); end
    tick();
  endtask

  task automatic test_handshake();
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at  = -1;
    do_start(8'h12, 8'h34, 1'b0, 1'b0);
    // k counts edges after E0; a start raised at k is sampled at edge E0+k+1.
    for (int k = 0; k < 24; k++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin done_cnt++; done_at = k; end
      if (k == 2 || k == WIDTH) begin
        start = 1'b1; a = 8'hFF; b = 8'h7F; sub = 1'b1; cin = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    n_cmp++; if (busy_cnt !== WIDTH + 1) begin n_err++; $display("FAIL hs_busy_cycles got=%0d exp=%0d", busy_cnt, WIDTH + 1); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL hs_done_count got=%0d exp=1", done_cnt); end
    n_cmp++; if (done_at !== WIDTH) begin n_err++; $display("FAIL hs_done_cycle got=%0d exp=%0d", done_at, WIDTH); end
    n_cmp++; if ({sum, cout, ovf} !== {8'h46, 1'b0, 1'b0}) begin n_err++; $display("FAIL hs_result got=%h/%b/%b exp=46/0/0", sum, cout, ovf); end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    int late_done = 0;
    do_start(8'h0F, 8'h01, 1'b0, 1'b0);
    tick(); tick(); tick();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_pre_busy got=%b exp=1", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL rst_async_status got=%b%b exp=00", busy, done); end
    n_cmp++; if ({sum, cout, ovf} !== 10'h0) begin n_err++; $display("FAIL rst_async_result got=%h/%b/%b exp=00/0/0", sum, cout, ovf); end
    n_cmp++; if ({cell_ai, cell_bi, cell_ci1} !== 3'b0) begin n_err++; $display("FAIL rst_async_cell got=%b exp=000", {cell_ai, cell_bi, cell_ci1}); end
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (done === 1'b1 || busy === 1'b1) late_done++;
      tick();
    end
    n_cmp++; if (late_done !== 0) begin n_err++; $display("FAIL rst_no_done got=%0d exp=0", late_done); end
    do_start(8'h0F, 8'h01, 1'b1, 1'b0);
    wait_done(cyc);
    n_cmp++; if (cyc !== WIDTH) begin n_err++; $display("FAIL rst_restart_latency got=%0d exp=%0d", cyc, WIDTH); end
    n_cmp++; if ({sum, cout, ovf} !== {8'h11, 1'b0, 1'b0}) begin n_err++; $display("FAIL rst_restart got=%h/%b/%b exp=11/0/0", sum, cout, ovf); end
    tick();
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] ra, rb, bb, exp_sum;
    logic             rc, rs, exp_cout, exp_ovf;
    int               cyc;
    int               fi_bad;
    for (int i = 0; i < 1000; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      bb = rs ? ~rb : rb;
      {exp_cout, exp_sum} = {1'b0, ra} + {1'b0, bb} + {{WIDTH{1'b0}}, (rs ? 1'b1 : rc)};
      exp_ovf = (ra[WIDTH-1] == bb[WIDTH-1]) && (exp_sum[WIDTH-1] != ra[WIDTH-1]);
      do_start(ra, rb, rc, rs);
      cyc = 0;
      fi_bad = 0;
      while (done !== 1'b1 && cyc < 40) begin
        if (cell_fi !== 1'b0) fi_bad++;
        tick();
        cyc++;
      end
      n_cmp++; if (cyc !== WIDTH) begin n_err++; $display("FAIL rnd_latency i=%0d got=%0d exp=%0d", i, cyc, WIDTH); end
      n_cmp++; if (fi_bad !== 0) begin n_err++; $display("FAIL rnd_cell_fi i=%0d got=%0d nonzero cycles exp=0", i, fi_bad); end
      n_cmp++; if (sum !== exp_sum) begin n_err++; $display("FAIL rnd_sum i=%0d a=%h b=%h cin=%b sub=%b got=%h exp=%h", i, ra, rb, rc, rs, sum, exp_sum); end
      n_cmp++; if (cout !== exp_cout) begin n_err++; $display("FAIL rnd_cout i=%0d a=%h b=%h sub=%b got=%b exp=%b", i, ra, rb, rs, cout, exp_cout); end
      n_cmp++; if (ovf !== exp_ovf) begin n_err++; $display("FAIL rnd_ovf i=%0d a=%h b=%h sub=%b got=%b exp=%b", i, ra, rb, rs, ovf, exp_ovf); end
      n_cmp++; if ({cell_ai, cell_bi, cell_ci1, cell_fi} !== 4'b0) begin n_err++; $display("FAIL rnd_cell_done i=%0d got=%b exp=0000", i, {cell_ai, cell_bi, cell_ci1, cell_fi}); end
      tick();
      n_cmp++; if ({busy, done, cell_ai, cell_bi, cell_ci1, cell_fi} !== 6'b0) begin n_err++; $display("FAIL rnd_idle i=%0d got=%b exp=000000", i, {busy, done, cell_ai, cell_bi, cell_ci1, cell_fi}); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ripple();
    test_sub();
    test_handshake();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
